// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - configurable up-counter sequencer with one-shot/auto-reload modes
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_reload,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wraps
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             reload_q, reload_d;
    logic [7:0]       wraps_q, wraps_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        wraps_d  = wraps_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    limit_d  = cfg_limit;
                    reload_d = cfg_reload;
                    count_d  = '0;
                    wraps_d  = '0;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (stop)       state_d = S_IDLE;
                else if (start) state_d = S_RUN;
            end
            S_RUN: begin
                // stop outranks pause; the count is frozen in both cases
                if (stop) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (count_q != limit_q) begin
                    count_d = count_q + 1'b1;
                end else if (!reload_q) begin
                    state_d = S_DONE;
                end else begin
                    count_d = '0;
                    if (wraps_q != 8'hFF) wraps_d = wraps_q + 8'd1;
                end
            end
            S_PAUSE: begin
                // the exit cycle only returns to RUN; counting resumes after it
                if (stop)        state_d = S_IDLE;
                else if (!pause) state_d = S_RUN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
            wraps_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            wraps_q  <= wraps_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_ARMED) || (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done      = (state_q == S_DONE);
    assign q         = count_q;
    assign wraps     = wraps_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - randomized bench for count_sequencer against a tick-count model
module tb_count_sequencer;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_limit;
    logic       cfg_reload;
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [7:0] wraps;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    count_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit), .cfg_reload(cfg_reload),
        .start(start), .pause(pause), .stop(stop),
        .q(q), .busy(busy), .done(done), .wraps(wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the count and wrap total are derived from the number of counting ticks since cfg
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    int m_mode  = M_IDLE;
    int m_lim   = 0;
    bit m_rel   = 0;
    int m_ticks = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_lim = 0; m_rel = 0; m_ticks = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (cfg_valid) begin
                             m_lim = int'(cfg_limit); m_rel = cfg_reload; m_ticks = 0; m_mode = M_ARMED;
                         end
                M_ARMED: if (stop) m_mode = M_IDLE; else if (start) m_mode = M_RUN;
                M_RUN:   if (stop) m_mode = M_IDLE;
                         else if (pause) m_mode = M_PAUSE;
                         else begin
                             if (!m_rel && m_ticks == m_lim) m_mode = M_DONE;
                             m_ticks = m_ticks + 1;
                         end
                M_PAUSE: if (stop) m_mode = M_IDLE; else if (!pause) m_mode = M_RUN;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int span, exp_q, exp_w;
            span  = m_lim + 1;
            exp_q = m_rel ? (m_ticks % span) : ((m_ticks < m_lim) ? m_ticks : m_lim);
            exp_w = m_rel ? (((m_ticks / span) > 255) ? 255 : (m_ticks / span)) : 0;
            chk("model_q", int'(q), exp_q);
            chk("model_wraps", int'(wraps), exp_w);
            chk("model_busy", int'(busy), int'(m_mode == M_ARMED || m_mode == M_RUN || m_mode == M_PAUSE));
            chk("model_done", int'(done), int'(m_mode == M_DONE));
            chk("model_cfg_ready", int'(cfg_ready), int'(m_mode == M_IDLE));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Leaves the DUT in its first RUN cycle (q=0)
    task automatic cfg_start(input int lim, input bit rel);
        cfg_valid = 1'b1; cfg_limit = 4'(lim); cfg_reload = rel;
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_lat(input int lim, input bit do_pause, output int lat);
        cfg_start(lim, 1'b0);
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            pause = do_pause && c >= 3 && c < 6;
            step();
        end
        pause = 1'b0;
        step();
    endtask

    initial begin
        int lat;
        reset = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_reload = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        step(2);
        check_en = 1'b1;
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wraps", int'(wraps), 0);
        reset = 1'b0;
        step();

        // one-shot limit 5
        cfg_start(5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("oneshot_q", int'(q), i);
            step();
        end
        chk("oneshot_done", int'(done), 1);
        step();
        chk("oneshot_done_end", int'(done), 0);
        chk("oneshot_hold_q", int'(q), 5);
        chk("oneshot_wraps", int'(wraps), 0);
        chk("oneshot_idle", int'(cfg_ready), 1);

        // auto-reload limit 2
        cfg_start(2, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("reload_q", int'(q), i % 3);
            if (i < 8) step();
        end
        chk("reload_wraps2", int'(wraps), 2);
        step();
        chk("reload_wraps3", int'(wraps), 3);
        stop = 1'b1; step(); stop = 1'b0;

        // latency with and without a pause window
        run_lat(7, 1'b0, lat);
        chk("latency_plain", lat, 8);
        run_lat(7, 1'b1, lat);
        chk("latency_paused", lat, 12);

        // stop and pause together at q=4
        cfg_start(9, 1'b0);
        step(4);
        chk("stop_pre_q", int'(q), 4);
        stop = 1'b1; pause = 1'b1; step(); stop = 1'b0; pause = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_q", int'(q), 4);
        chk("stop_ready", int'(cfg_ready), 1);
        start = 1'b1; step(); start = 1'b0;
        chk("idle_start_ignored", int'(busy), 0);

        // limit 0 one-shot
        cfg_start(0, 1'b0);
        chk("lim0_first", int'(done), 0);
        step();
        chk("lim0_done", int'(done), 1);
        step();

        // reset mid-run
        cfg_start(3, 1'b1);
        step(5);
        reset = 1'b1;
        #1;
        chk("mid_rst_q", int'(q), 0);
        chk("mid_rst_wraps", int'(wraps), 0);
        chk("mid_rst_ready", int'(cfg_ready), 1);
        chk("mid_rst_done", int'(done), 0);
        step();
        reset = 1'b0;
        step();

        // wraps saturation, cfg ignored while running
        cfg_start(0, 1'b1);
        step(300);
        chk("sat_wraps", int'(wraps), 255);
        cfg_valid = 1'b1; cfg_limit = 4'd6;
        #1;
        chk("run_cfg_ready", int'(cfg_ready), 0);
        step();
        cfg_valid = 1'b0;
        chk("run_cfg_ignored", int'(busy), 1);
        stop = 1'b1; step(); stop = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_limit  = 4'($urandom_range(0, 15));
            cfg_reload = 1'($urandom_range(0, 1));
            start      = ($urandom_range(0, 2) == 0);
            pause      = ($urandom_range(0, 4) == 0);
            stop       = ($urandom_range(0, 24) == 0);
            step();
        end
        reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
